// File: rtl/storage_cache_pkg.sv
// Shared types and address-split helpers for the storage cache controller.
package storage_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCRATCH = 3'd1,
    ST_LOOKUP  = 3'd2,
    ST_REFILL  = 3'd3,
    ST_RESPOND = 3'd4,
    ST_ERROR   = 3'd5,
    ST_PROG    = 3'd6
  } state_e;

  localparam logic [31:0] SCRATCH_BASE = 32'h0000_0000;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int ext_aw, input int line_words, input int num_lines);
    return ext_aw - off_w(line_words) - idx_w(num_lines);
  endfunction

  // A zero-width field still needs a one-bit register to hold it.
  function automatic int safe_w(input int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/storage_cache_if.sv
// Core-side request/response port of the storage cache controller.
interface storage_cache_if #(
  parameter int MEM_W = 32
) ();
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [31:0]        req_addr;
  logic [MEM_W-1:0]   req_wdata;
  logic [MEM_W/8-1:0] req_be;
  logic               rsp_valid;
  logic [MEM_W-1:0]   rsp_rdata;
  logic               rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/storage_cache_tags.sv
// Valid/tag store of the direct-mapped line cache: combinational lookup, single-line fill, bulk invalidate.
module storage_cache_tags
  import storage_cache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int TAG_W     = 16,
  parameter int IDX_W     = idx_w(NUM_LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_lk_idx,
  input  logic [TAG_W-1:0] i_lk_tag,
  output logic             o_hit,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic             i_inv_all
);
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag [NUM_LINES];

  // Valid bits: invalidate-all wins over a same-cycle line fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= {NUM_LINES{1'b0}};
    end else if (i_inv_all) begin
      r_valid <= {NUM_LINES{1'b0}};
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag array needs no reset; a tag is only trusted behind its valid bit.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx] <= i_wr_tag;
    end
  end

  assign o_hit = r_valid[i_lk_idx] && (r_tag[i_lk_idx] == i_lk_tag);
endmodule

// File: rtl/storage_cache_ctrl.sv
// Storage controller: scratch SRAM at address 0 plus a direct-mapped line cache over read-only SPI storage.
module storage_cache_ctrl
  import storage_cache_pkg::*;
#(
  parameter int MEM_W         = 32,
  parameter int SCRATCH_BYTES = 8192,
  parameter int LINE_WORDS    = 4,
  parameter int NUM_LINES     = 16,
  parameter int EXT_AW        = 22
) (
  input  logic              clk,
  input  logic              rst,
  storage_cache_if.slave    bus,
  output logic              o_ext_req,
  output logic [EXT_AW-1:0] o_ext_addr,
  input  logic              i_ext_ack,
  input  logic [MEM_W-1:0]  i_ext_rdata,
  input  logic              i_prog_mode,
  output logic              o_prog_active,
  input  logic              i_flush,
  output logic              o_busy
);
  localparam int BYTES_W   = MEM_W / 8;
  localparam int BYTE_SH   = $clog2(BYTES_W);
  localparam int OFF_W     = off_w(LINE_WORDS);
  localparam int IDX_W     = idx_w(NUM_LINES);
  localparam int TAG_W     = tag_w(EXT_AW, LINE_WORDS, NUM_LINES);
  localparam int CNT_W     = safe_w(OFF_W);
  localparam int DA_W      = OFF_W + IDX_W;
  localparam int SCR_WORDS = SCRATCH_BYTES / BYTES_W;
  localparam int SCR_AW    = $clog2(SCR_WORDS);
  localparam logic [31:0]       EXT_BASE = SCRATCH_BASE + 32'(SCRATCH_BYTES);
  localparam logic [EXT_AW-1:0] OFF_MASK = EXT_AW'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LINE_WORDS - 1);

  state_e             r_state;
  logic               r_idle, r_busy, r_rsp_valid, r_rsp_err, r_ext_req, r_prog;
  logic [MEM_W-1:0]   r_rsp_rdata, r_miss_data;
  logic [EXT_AW-1:0]  r_ext_addr;
  logic [CNT_W-1:0]   r_cnt, r_req_off;
  logic [MEM_W-1:0]   r_scr [SCR_WORDS];
  logic [MEM_W-1:0]   r_dat [NUM_LINES*LINE_WORDS];

  logic [31:0]        w_scr_off, w_ext_off, w_ext_word32;
  logic [EXT_AW-1:0]  w_ext_word, w_line_base;
  logic [SCR_AW-1:0]  w_scr_idx;
  logic [DA_W-1:0]    w_dat_idx;
  logic               w_is_scr, w_is_ext, w_hit, w_accept, w_scr_wr, w_fill, w_fill_last, w_inv_all;

  assign w_scr_off    = bus.req_addr - SCRATCH_BASE;
  assign w_ext_off    = bus.req_addr - EXT_BASE;
  assign w_ext_word32 = w_ext_off >> BYTE_SH;
  assign w_ext_word   = w_ext_word32[EXT_AW-1:0];
  assign w_is_scr     = w_scr_off < 32'(SCRATCH_BYTES);
  assign w_is_ext     = !w_is_scr && (w_ext_word32[31:EXT_AW] == {(32-EXT_AW){1'b0}});
  assign w_line_base  = w_ext_word & ~OFF_MASK;
  assign w_scr_idx    = w_scr_off[BYTE_SH +: SCR_AW];
  assign w_dat_idx    = w_ext_word[DA_W-1:0];
  assign w_accept     = bus.req_valid && bus.req_ready;
  assign w_scr_wr     = w_accept && w_is_scr && bus.req_we;
  assign w_fill       = (r_state == ST_REFILL) && i_ext_ack;
  assign w_fill_last  = w_fill && (r_cnt == LAST_CNT);
  // Flush only counts in IDLE when programming mode is not also requested; leaving PROG wipes the cache.
  assign w_inv_all    = ((r_state == ST_IDLE) && !i_prog_mode && i_flush) ||
                        ((r_state == ST_PROG) && !i_prog_mode);

  storage_cache_tags #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_tags (
    .clk       (clk),
    .rst       (rst),
    .i_lk_idx  (w_ext_word[OFF_W +: IDX_W]),
    .i_lk_tag  (w_ext_word[EXT_AW-1 -: TAG_W]),
    .o_hit     (w_hit),
    .i_wr_en   (w_fill_last),
    .i_wr_idx  (r_ext_addr[OFF_W +: IDX_W]),
    .i_wr_tag  (r_ext_addr[EXT_AW-1 -: TAG_W]),
    .i_inv_all (w_inv_all)
  );

  assign bus.req_ready = r_idle && !i_prog_mode && !i_flush;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign o_ext_req     = r_ext_req;
  assign o_ext_addr    = r_ext_addr;
  assign o_prog_active = r_prog;
  assign o_busy        = r_busy;

  // Single-port scratch and line-data arrays: byte-enabled scratch writes, whole-word refill writes.
  always_ff @(posedge clk) begin
    if (w_scr_wr) begin
      for (int b = 0; b < BYTES_W; b++) begin
        if (bus.req_be[b]) begin
          r_scr[w_scr_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
      end
    end
    if (w_fill) begin
      r_dat[r_ext_addr[DA_W-1:0]] <= i_ext_rdata;
    end
  end

  // Control FSM with registered response, external-request and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idle      <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {MEM_W{1'b0}};
      r_rsp_err   <= 1'b0;
      r_ext_req   <= 1'b0;
      r_ext_addr  <= {EXT_AW{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_req_off   <= {CNT_W{1'b0}};
      r_miss_data <= {MEM_W{1'b0}};
      r_prog      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_prog_mode) begin
            r_state <= ST_PROG;
            r_idle  <= 1'b0;
            r_busy  <= 1'b1;
            r_prog  <= 1'b1;
          end else if (w_accept) begin
            r_idle <= 1'b0;
            r_busy <= 1'b1;
            if (w_is_scr) begin
              r_state     <= ST_SCRATCH;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= bus.req_we ? {MEM_W{1'b0}} : r_scr[w_scr_idx];
            end else if (w_is_ext && !bus.req_we && w_hit) begin
              r_state     <= ST_LOOKUP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= r_dat[w_dat_idx];
            end else if (w_is_ext && !bus.req_we) begin
              r_state    <= ST_REFILL;
              r_ext_req  <= 1'b1;
              r_ext_addr <= w_line_base;
              r_cnt      <= {CNT_W{1'b0}};
              r_req_off  <= CNT_W'(w_ext_word & OFF_MASK);
            end else begin
              r_state     <= ST_ERROR;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= {MEM_W{1'b0}};
            end
          end
        end
        ST_REFILL: begin
          if (i_ext_ack) begin
            if (r_cnt == r_req_off) begin
              r_miss_data <= i_ext_rdata;
            end
            if (r_cnt == LAST_CNT) begin
              r_ext_req <= 1'b0;
              r_state   <= ST_RESPOND;
            end else begin
              r_cnt      <= r_cnt + CNT_W'(1);
              r_ext_addr <= r_ext_addr + EXT_AW'(1);
            end
          end
        end
        ST_RESPOND: begin
          r_state     <= ST_IDLE;
          r_idle      <= 1'b1;
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_miss_data;
        end
        ST_PROG: begin
          if (!i_prog_mode) begin
            r_state <= ST_IDLE;
            r_idle  <= 1'b1;
            r_busy  <= 1'b0;
            r_prog  <= 1'b0;
          end
        end
        ST_SCRATCH, ST_LOOKUP, ST_ERROR: begin
          r_state <= ST_IDLE;
          r_idle  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_idle  <= 1'b1;
          r_busy  <= 1'b0;
          r_prog  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_storage_cache_ctrl.sv
// Directed bench for storage_cache_ctrl: scratch, cache hit/miss/refill, errors, flush, prog mode, mid-refill reset.
module tb_storage_cache_ctrl;
  localparam int ACK_LAT = 3;
  localparam int MISS_LAT = 2 + 4 * ACK_LAT;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_req;
  logic [21:0] ext_addr;
  logic        ext_ack;
  logic [31:0] ext_rdata;
  logic        prog_mode, prog_active, flush, busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_cnt = 0;
  int          n_acks  = 0;
  logic [21:0] ack_log [64];

  storage_cache_if #(.MEM_W(32)) bus ();

  storage_cache_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .o_ext_req     (ext_req),
    .o_ext_addr    (ext_addr),
    .i_ext_ack     (ext_ack),
    .i_ext_rdata   (ext_rdata),
    .i_prog_mode   (prog_mode),
    .o_prog_active (prog_active),
    .i_flush       (flush),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [21:0] a);
    return {10'h2A5, a};
  endfunction

  // SPI engine model: acknowledges in the ACK_LAT-th cycle a request is held.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      ack_cnt <= 0;
      ext_ack <= 1'b0;
      ext_rdata <= 32'h0;
    end else if (ext_req && ack_cnt == ACK_LAT - 1) begin
      ext_ack   <= 1'b1;
      ext_rdata <= pat(ext_addr);
      if (n_acks < 64) ack_log[n_acks] <= ext_addr;
      n_acks  <= n_acks + 1;
      ack_cnt <= 0;
    end else if (ext_req) begin
      ext_ack <= 1'b0;
      ack_cnt <= ack_cnt + 1;
    end else begin
      ext_ack <= 1'b0;
      ack_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_req(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    @(negedge clk);
    chk("req_ready", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int lat, output logic [31:0] rd, output logic er);
    lat = start;
    while (bus.rsp_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_seen", 64'(bus.rsp_valid), 64'd1);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
  endtask

  task automatic access(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    int a0;
    logic [31:0] rd;
    logic er;
    a0 = n_acks;
    issue_req(we, addr, wd, be);
    wait_rsp(1, lat, rd, er);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
    chk({tag, "_err"}, 64'(er), 64'(exp_err));
    if (exp_lat == 1) chk({tag, "_no_ext"}, 64'(n_acks - a0), 64'd0);
    else chk({tag, "_acks"}, 64'(n_acks - a0), 64'd4);
  endtask

  task automatic miss_read(input string tag, input logic [31:0] addr, input logic [21:0] base, input logic [21:0] want);
    int a0;
    a0 = n_acks;
    access(tag, 1'b0, addr, 32'h0, 4'h0, MISS_LAT, pat(want), 1'b0);
    for (int i = 0; i < 4; i++) chk({tag, "_ext_addr"}, 64'(ack_log[a0 + i]), 64'(base + 22'(i)));
    chk({tag, "_ext_req_low"}, 64'(ext_req), 64'd0);
  endtask

  initial begin
    int lat;
    int a0;
    logic [31:0] rd;
    logic er;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_be    = 4'h0;
    prog_mode = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_ext_req", 64'(ext_req), 64'd0);
    chk("rst_ext_addr", 64'(ext_addr), 64'd0);
    chk("rst_prog", 64'(prog_active), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // Scratch: clear word, two byte-enabled writes, reads return merged word.
    access("scr_clr", 1'b1, 32'h10, 32'h0, 4'hF, 1, 32'h0, 1'b0);
    access("scr_wr1", 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 1, 32'h0, 1'b0);
    access("scr_rd1", 1'b0, 32'h10, 32'h0, 4'h0, 1, 32'h00BB00DD, 1'b0);
    @(negedge clk);
    chk("rsp_pulse", 64'(bus.rsp_valid), 64'd0);
    access("scr_wr2", 1'b1, 32'h10, 32'h11223344, 4'b1010, 1, 32'h0, 1'b0);
    access("scr_rd2", 1'b0, 32'h10, 32'h0, 4'hF, 1, 32'h11BB33DD, 1'b0);

    // External region: miss/refill, then hits within the line.
    miss_read("miss0", 32'h2000, 22'd0, 22'd0);
    access("hit1", 1'b0, 32'h2004, 32'h0, 4'h0, 1, pat(22'd1), 1'b0);
    access("hit3", 1'b0, 32'h200C, 32'h0, 4'h0, 1, pat(22'd3), 1'b0);

    // Errors: external write and out-of-range read leave the cache alone.
    access("ext_wr", 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1, 32'h0, 1'b1);
    access("hit0", 1'b0, 32'h2000, 32'h0, 4'h0, 1, pat(22'd0), 1'b0);
    access("oor", 1'b0, 32'h0100_2000, 32'h0, 4'h0, 1, 32'h0, 1'b1);

    // Flush in IDLE blocks acceptance and invalidates.
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    miss_read("flush_miss", 32'h2000, 22'd0, 22'd0);

    // Same index, different tag; requested word is not at offset 0.
    miss_read("alias_miss", 32'h2108, 22'd64, 22'd66);
    access("alias_hit", 1'b0, 32'h2104, 32'h0, 4'h0, 1, pat(22'd65), 1'b0);

    // prog_mode raised mid-refill: refill finishes, then PROG, exit invalidates.
    a0 = n_acks;
    issue_req(1'b0, 32'h2010, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("prog_busy_refill", 64'(busy), 64'd1);
    chk("prog_ext_req_refill", 64'(ext_req), 64'd1);
    prog_mode = 1'b1;
    wait_rsp(4, lat, rd, er);
    chk("prog_lat", 64'(lat), 64'(MISS_LAT));
    chk("prog_rdata", 64'(rd), 64'(pat(22'd4)));
    chk("prog_err", 64'(er), 64'd0);
    chk("prog_acks", 64'(n_acks - a0), 64'd4);
    @(negedge clk);
    chk("prog_active", 64'(prog_active), 64'd1);
    chk("prog_ready", 64'(bus.req_ready), 64'd0);
    chk("prog_busy", 64'(busy), 64'd1);
    chk("prog_ext_req", 64'(ext_req), 64'd0);
    prog_mode = 1'b0;
    @(negedge clk);
    chk("unprog_active", 64'(prog_active), 64'd0);
    chk("unprog_busy", 64'(busy), 64'd0);
    chk("unprog_ready", 64'(bus.req_ready), 64'd1);
    miss_read("post_prog", 32'h2010, 22'd4, 22'd4);

    // Async reset while waiting on the second ack of a refill.
    issue_req(1'b0, 32'h2020, 32'h0, 4'h0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_ext_req", 64'(ext_req), 64'd0);
    chk("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    miss_read("rst_miss", 32'h2020, 22'd8, 22'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/storage_cache_ctrl.md
Name: storage_cache_ctrl

Overview:
- Parametrised successor to the single-port storage controller.
- Fronts a low-latency on-chip scratch region and a read-only external SPI storage region, and caches the external region in a direct-mapped line cache.
- Adds byte-enabled scratch writes, multi-word line refill, explicit flush and an error response.
- Programming mode is enterable and exitable at runtime. The cache is invalidated on exit.
- Sits between the vector core memory port and the SPI flash word-read engine.

Parameters:
MEM_W, 32, data bus width in bits; must be 32 or 64
SCRATCH_BYTES, 8192, size of the scratch region at address 0; power of two
LINE_WORDS, 4, MEM_W-wide words per cache line; power of two, 1 to 16
NUM_LINES, 16, cache lines; power of two
EXT_AW, 22, external storage word-address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  core request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1 = write
req_addr  in  32  byte address
req_wdata  in  MEM_W  write data
req_be  in  MEM_W/8  byte enables
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  MEM_W  read data; 0 on writes and errors
rsp_err  out  1  with rsp_valid: write to external region or out-of-range address
ext_req  out  1  word-read request to SPI engine; held until ext_ack
ext_addr  out  EXT_AW  external word address
ext_ack  in  1  read complete; ext_rdata valid this cycle
ext_rdata  in  MEM_W  external read data
prog_mode  in  1  request programming passthrough
prog_active  out  1  controller is in PROG; SPI pin mux select
flush  in  1  invalidate all lines
busy  out  1  state is not IDLE

Behaviour:
- Reset: state IDLE; all valid bits 0; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; ext_req=0; ext_addr=0; prog_active=0; busy=0.
- Handshake: a request is accepted when req_valid && req_ready. req_ready=1 only in IDLE with prog_mode=0 and flush=0. At most one outstanding request.
- Address decode, word aligned (low log2(MEM_W/8) bits ignored):
  - scratch: addr < SCRATCH_BYTES.
  - external: addr - SCRATCH_BYTES, as a word index, < 2^EXT_AW.
  - anything else is out of range.
- External address fields: word = (addr-SCRATCH_BYTES)>>log2(MEM_W/8), split into offset | index | tag (low to high).
- IDLE priority, highest first: prog_mode -> PROG; flush -> clear all valid bits this cycle, stay IDLE; accepted request.
- Scratch access:
  - Completes in SCRATCH state; rsp_valid asserts exactly 1 cycle after acceptance.
  - Writes update only the bytes with req_be set.
  - Reads return the full word and ignore be.
- External read, hit: rsp_valid 1 cycle after acceptance (LOOKUP state), rsp_rdata = cached word.
- External read, miss (REFILL):
  - Fetches LINE_WORDS words, line-aligned, offset 0 first.
  - ext_req stays high with a stable ext_addr until ext_ack; the next word is requested the cycle after each ack.
  - After the last ack: write tag, set valid, go to RESPOND, emit rsp_valid the following cycle, return to IDLE.
  - Miss latency = 2 + sum of ext acknowledge latencies.
- External write or out of range: rsp_valid=1, rsp_err=1 in the cycle after acceptance; no state or cache change.
- ext_ack outside REFILL is ignored.
- flush or prog_mode asserted during REFILL is not acted on until IDLE. The refill completes normally.
- PROG:
  - prog_active=1, req_ready=0, ext_req=0.
  - When prog_mode falls: invalidate all lines, then go to IDLE the next cycle.
- Async reset mid-refill: ext_req drops immediately, the line stays invalid, and no response is issued.
- State encoding: IDLE, SCRATCH, LOOKUP, REFILL, RESPOND, ERROR, PROG.

Decomposition:
- Package storage_cache_pkg holds:
  - the state enum;
  - address-split helper widths (OFF_W, IDX_W, TAG_W) as functions of the parameters;
  - the scratch base constant.
- One sub-module, storage_cache_tags: valid/tag array with lookup, single-line write and bulk invalidate. Data and scratch arrays stay in the top level behind a single-port SRAM wrapper.

Test Plan:
- Scratch write addr 0x10, wdata 0xAABBCCDD, be 0b0101; then read 0x10 -> rsp_rdata 0x00BB00DD one cycle after acceptance, rsp_err=0.
- Read 0x2000 with LINE_WORDS=4 and a 3-cycle ext_ack model -> ext_addr 0,1,2,3 in order; rsp_valid at cycle 2+4×3 after acceptance with word 0 data. Read 0x2004 -> hit, 1-cycle response, no ext_req.
- Write to 0x2000 -> rsp_err=1, rsp_rdata=0, cache unchanged (a following read of 0x2000 still hits).
- Fill line 0, pulse flush in IDLE, re-read 0x2000 -> miss and refill observed.
- Assert prog_mode during REFILL -> refill completes and responds, then prog_active=1, req_ready=0. Deassert -> all lines invalid, IDLE.
- Assert rst on the 2nd ext_ack wait -> ext_req=0 and rsp_valid=0 immediately. After release, the same read misses again.
